// File: rtl/chip8_draw_pkg.sv
// -----------------------------------------------------------------------------
// chip8_draw_pkg
// Shared types and constants for the CHIP-8 sprite-draw / screen-clear engine.
//   u12          : main-memory address (4 KiB space)
//   fb_row_t     : one framebuffer row, one bit per pixel, column 0 at bit 63
//   draw_state_t : engine sequencer states
//   sprite_mask  : places an 8-pixel sprite byte at column x0 with right clip
// -----------------------------------------------------------------------------
package chip8_draw_pkg;

    localparam int FB_W = 64;
    localparam int FB_H = 32;
    localparam int AW   = 12;

    typedef logic [AW-1:0]   u12;
    typedef logic [FB_W-1:0] fb_row_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        CLR  = 3'd3,
        DONE = 3'd4
    } draw_state_t;

    // Sprite bit7 lands on column x0 (fb bit 63-x0); pixels shifted past
    // column 63 fall off the right edge instead of wrapping to column 0.
    function automatic fb_row_t sprite_mask(input logic [7:0] sprite, input logic [5:0] x0);
        sprite_mask = {sprite, 56'h00_0000_0000_0000} >> x0;
    endfunction

endpackage

// File: rtl/chip8_draw_if.sv
// -----------------------------------------------------------------------------
// chip8_draw_if
// Bundles the engine's three buses:
//   command  : cmd_valid/cmd_ready handshake, cmd_clear/x/y/n/i operands,
//              done pulse and collision (VF) result back to the cpu
//   memory   : mem_addr/mem_rd out, mem_rdata in (one-cycle read latency)
//   fb RAM   : fb_addr/fb_rd/fb_we/fb_wdata out, fb_rdata in (one-cycle read)
// slave  modport: the draw engine.
// master modport: the surrounding system (cpu, main memory, framebuffer RAM).
// -----------------------------------------------------------------------------
interface chip8_draw_if;
    import chip8_draw_pkg::*;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_clear;
    logic [7:0]  cmd_x;
    logic [7:0]  cmd_y;
    logic [3:0]  cmd_n;
    u12          cmd_i;

    u12          mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;

    logic [4:0]  fb_addr;
    logic        fb_rd;
    fb_row_t     fb_rdata;
    logic        fb_we;
    fb_row_t     fb_wdata;

    logic        done;
    logic        collision;

    modport slave (
        input  cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_n, cmd_i,
        input  mem_rdata, fb_rdata,
        output cmd_ready, mem_addr, mem_rd, fb_addr, fb_rd, fb_we, fb_wdata,
        output done, collision
    );

    modport master (
        output cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_n, cmd_i,
        output mem_rdata, fb_rdata,
        input  cmd_ready, mem_addr, mem_rd, fb_addr, fb_rd, fb_we, fb_wdata,
        input  done, collision
    );

endinterface

// File: rtl/chip8_draw_row.sv
// -----------------------------------------------------------------------------
// chip8_draw_row
// Combinational XOR-draw of one sprite byte into one framebuffer row.
//   sprite  in  8     sprite byte, bit7 = leftmost pixel
//   x0      in  6     start column (already reduced mod 64)
//   old_row in  FB_W  current row contents
//   new_row out FB_W  row after XOR with the clipped sprite
//   hit     out 1     1 if any lit pixel was turned off (row collision)
// -----------------------------------------------------------------------------
module chip8_draw_row
    import chip8_draw_pkg::*;
(
    input  logic [7:0] sprite,
    input  logic [5:0] x0,
    input  fb_row_t    old_row,
    output fb_row_t    new_row,
    output logic       hit
);

    fb_row_t mask_s;

    assign mask_s  = sprite_mask(sprite, x0);
    assign new_row = old_row ^ mask_s;
    assign hit     = |(old_row & mask_s);

endmodule

// File: rtl/chip8_draw_engine.sv
// -----------------------------------------------------------------------------
// chip8_draw_engine
// Executes DXYN (sprite draw with XOR and collision) and 00E0 (screen clear)
// for the cpu against a row-organised 64x32 framebuffer RAM.
//   clk  in  system clock
//   rst  in  asynchronous active-low reset
//   bus  chip8_draw_if.slave : command handshake, main-memory read port,
//        framebuffer read/write port, done/collision result
// Draw: two cycles per row (RD issues both reads, WR writes the XORed row).
// Clear: one zero row per cycle, rows 0..31.
// done/collision are presented for one cycle after the DONE state, while the
// engine is already idle again.
// -----------------------------------------------------------------------------
module chip8_draw_engine
    import chip8_draw_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    chip8_draw_if.slave  bus
);

    draw_state_t state_r;

    // Latched command operands
    logic [5:0]  x0_r;
    logic [4:0]  y0_r;
    logic [3:0]  n_r;
    u12          i_r;
    logic [3:0]  r_r;
    logic        acc_r;

    // Registered outputs
    logic        cmd_ready_r;
    u12          mem_addr_r;
    logic        mem_rd_r;
    logic [4:0]  fb_addr_r;
    logic        fb_rd_r;
    logic        fb_we_r;
    logic        done_r;
    logic        collision_r;

    // Row datapath and sequencing helpers
    fb_row_t     row_new_s;
    logic        row_hit_s;
    logic [3:0]  next_r_s;
    logic        more_rows_s;
    logic [5:0]  cmd_x0_s;
    logic [4:0]  cmd_y0_s;

    chip8_draw_row u_row (
        .sprite  (bus.mem_rdata),
        .x0      (x0_r),
        .old_row (bus.fb_rdata),
        .new_row (row_new_s),
        .hit     (row_hit_s)
    );

    // Start position wraps onto the screen; only the start wraps, the sprite
    // itself is clipped at the right and bottom edges.
    assign cmd_x0_s = 6'(bus.cmd_x % 8'd64);
    assign cmd_y0_s = 5'(bus.cmd_y % 8'd32);

    // Continue with another row only if the sprite has more bytes and the
    // next row is still on screen (vertical clip).
    always_comb begin
        next_r_s = r_r + 4'd1;
        if (({2'b00, next_r_s} < {2'b00, n_r}) &&
            (({1'b0, y0_r} + {2'b00, next_r_s}) < 6'd32)) begin
            more_rows_s = 1'b1;
        end else begin
            more_rows_s = 1'b0;
        end
    end

    // Sequencer: command acceptance, row read/write pacing, clear sweep, done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            x0_r        <= 6'd0;
            y0_r        <= 5'd0;
            n_r         <= 4'd0;
            i_r         <= 12'd0;
            r_r         <= 4'd0;
            acc_r       <= 1'b0;
            cmd_ready_r <= 1'b1;
            mem_addr_r  <= 12'd0;
            mem_rd_r    <= 1'b0;
            fb_addr_r   <= 5'd0;
            fb_rd_r     <= 1'b0;
            fb_we_r     <= 1'b0;
            done_r      <= 1'b0;
            collision_r <= 1'b0;
        end else begin
            done_r      <= 1'b0;
            collision_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        cmd_ready_r <= 1'b0;
                        x0_r        <= cmd_x0_s;
                        y0_r        <= cmd_y0_s;
                        n_r         <= bus.cmd_n;
                        i_r         <= bus.cmd_i;
                        r_r         <= 4'd0;
                        acc_r       <= 1'b0;
                        if (bus.cmd_clear) begin
                            state_r   <= CLR;
                            fb_addr_r <= 5'd0;
                            fb_we_r   <= 1'b1;
                        end else if (bus.cmd_n == 4'd0) begin
                            state_r <= DONE;
                        end else begin
                            // Issue the first row's reads on the accept edge
                            state_r    <= RD;
                            mem_addr_r <= bus.cmd_i;
                            fb_addr_r  <= cmd_y0_s;
                            mem_rd_r   <= 1'b1;
                            fb_rd_r    <= 1'b1;
                        end
                    end
                end
                RD: begin
                    mem_rd_r <= 1'b0;
                    fb_rd_r  <= 1'b0;
                    fb_we_r  <= 1'b1;
                    state_r  <= WR;
                end
                WR: begin
                    fb_we_r <= 1'b0;
                    acc_r   <= acc_r | row_hit_s;
                    r_r     <= next_r_s;
                    if (more_rows_s) begin
                        state_r    <= RD;
                        mem_addr_r <= i_r + {8'h00, next_r_s};
                        fb_addr_r  <= y0_r + {1'b0, next_r_s};
                        mem_rd_r   <= 1'b1;
                        fb_rd_r    <= 1'b1;
                    end else begin
                        state_r <= DONE;
                    end
                end
                CLR: begin
                    if (fb_addr_r == 5'd31) begin
                        fb_we_r <= 1'b0;
                        state_r <= DONE;
                    end else begin
                        fb_addr_r <= fb_addr_r + 5'd1;
                    end
                end
                DONE: begin
                    done_r      <= 1'b1;
                    collision_r <= acc_r;
                    cmd_ready_r <= 1'b1;
                    state_r     <= IDLE;
                end
                default: begin
                    state_r     <= IDLE;
                    cmd_ready_r <= 1'b1;
                    mem_rd_r    <= 1'b0;
                    fb_rd_r     <= 1'b0;
                    fb_we_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_rd    = mem_rd_r;
    assign bus.fb_addr   = fb_addr_r;
    assign bus.fb_rd     = fb_rd_r;
    assign bus.fb_we     = fb_we_r;
    assign bus.done      = done_r;
    assign bus.collision = collision_r;

    // The XORed row must be written in the same cycle the old row arrives from
    // the RAM, so write data is formed directly from fb_rdata; outside WR it is
    // forced to zero, which is also the clear pattern.
    assign bus.fb_wdata = (state_r == WR) ? row_new_s : 64'h0;

endmodule

// File: tb/tb_chip8_draw_engine.sv
module tb_chip8_draw_engine;
    import chip8_draw_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    chip8_draw_if bus();

    chip8_draw_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          edge_n;
        int          addr;
        logic [63:0] data;
    } wr_t;

    logic [7:0]  mem    [0:4095];
    logic [63:0] fb     [0:31] = '{default: 64'h0};
    logic [63:0] ref_fb [0:31] = '{default: 64'h0};

    int   cyc = 0;
    int   pass_cnt = 0;
    int   chk_cnt = 0;

    wr_t  exp_q[$];
    wr_t  obs_q[$];
    int   done_q[$];
    logic coll_q[$];
    int   rd_q[$];
    int   fbrd_q[$];

    // Memory and framebuffer RAM models, one-cycle read latency
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
        if (bus.fb_rd)  bus.fb_rdata  <= fb[bus.fb_addr];
        if (bus.fb_we)  fb[bus.fb_addr] <= bus.fb_wdata;
    end

    // Monitor: record DUT activity; a write seen now commits at edge cyc+1
    always @(negedge clk) begin
        if (bus.fb_we)  obs_q.push_back('{cyc + 1, int'(bus.fb_addr), bus.fb_wdata});
        if (bus.done) begin
            done_q.push_back(cyc);
            coll_q.push_back(bus.collision);
        end
        if (bus.mem_rd) rd_q.push_back(int'(bus.mem_addr));
        if (bus.fb_rd)  fbrd_q.push_back(int'(bus.fb_addr));
    end

    task automatic issue(input logic clr, input int x, input int y, input int n,
                         input int i, output int t);
        @(negedge clk);
        bus.cmd_clear = clr;
        bus.cmd_x     = 8'(x);
        bus.cmd_y     = 8'(y);
        bus.cmd_n     = 4'(n);
        bus.cmd_i     = 12'(i);
        bus.cmd_valid = 1'b1;
        t = -100;
        for (int k = 0; k < 50; k++) begin
            if (bus.cmd_ready === 1'b1) begin
                t = cyc + 1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, output int d);
        d = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            if (done_q.size() > d0) begin
                d = done_q[d0];
                break;
            end
        end
    endtask

    // Reference draw: pixel-by-pixel placement with right clip and bottom clip
    task automatic model_draw(input int x, input int y, input int n, input int i,
                              input int t, input int lim, output logic coll, output int rows);
        int x0;
        int y0;
        logic [63:0] m;
        logic [7:0]  b;
        x0 = x % 64;
        y0 = y % 32;
        coll = 1'b0;
        rows = 0;
        for (int r = 0; r < n && r < lim; r++) begin
            if (y0 + r > 31) break;
            b = mem[(i + r) % 4096];
            m = 64'h0;
            for (int k = 0; k < 8; k++) begin
                if (x0 + k < 64) m[63 - (x0 + k)] = b[7 - k];
            end
            if ((ref_fb[y0 + r] & m) != 64'h0) coll = 1'b1;
            ref_fb[y0 + r] = ref_fb[y0 + r] ^ m;
            exp_q.push_back('{t + 2 * (r + 1), y0 + r, ref_fb[y0 + r]});
            rows++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_clear = 1'b0;
        bus.cmd_x = 8'd0;
        bus.cmd_y = 8'd0;
        bus.cmd_n = 4'd0;
        bus.cmd_i = 12'd0;
        repeat (2) @(negedge clk);
        chk_cnt++;
        if (bus.cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.cmd_ready);
        else pass_cnt++;
        chk_cnt++;
        if ({bus.mem_rd, bus.fb_rd, bus.fb_we, bus.done, bus.collision} !== 5'b0)
            $display("FAIL reset_strobes: got %b want 00000",
                     {bus.mem_rd, bus.fb_rd, bus.fb_we, bus.done, bus.collision});
        else pass_cnt++;
        chk_cnt++;
        if (bus.mem_addr !== 12'h0 || bus.fb_addr !== 5'h0 || bus.fb_wdata !== 64'h0)
            $display("FAIL reset_addr: got %h/%h/%h want 0/0/0", bus.mem_addr, bus.fb_addr, bus.fb_wdata);
        else pass_cnt++;
        rst = 1'b1;
    endtask

    // Draw scenario: scoreboard of row writes, done timing and collision
    task automatic test_draw(input string name, input int x, input int y, input int n,
                             input int i, output int t);
        int   w0;
        int   d0;
        int   rows;
        int   d;
        logic ec;
        wr_t  e;
        wr_t  o;
        w0 = obs_q.size();
        d0 = done_q.size();
        issue(1'b0, x, y, n, i, t);
        model_draw(x, y, n, i, t, 16, ec, rows);
        wait_done(d0, d);
        chk_cnt++;
        if (obs_q.size() - w0 !== rows)
            $display("FAIL %s_wcount: got %0d want %0d", name, obs_q.size() - w0, rows);
        else pass_cnt++;
        for (int k = 0; k < rows; k++) begin
            e = exp_q.pop_front();
            chk_cnt++;
            if (w0 + k >= obs_q.size()) begin
                $display("FAIL %s_row%0d: got no write want row %0d data %h", name, k, e.addr, e.data);
            end else begin
                o = obs_q[w0 + k];
                if (o.edge_n !== e.edge_n || o.addr !== e.addr || o.data !== e.data)
                    $display("FAIL %s_row%0d: got edge %0d row %0d data %h want edge %0d row %0d data %h",
                             name, k, o.edge_n, o.addr, o.data, e.edge_n, e.addr, e.data);
                else pass_cnt++;
            end
        end
        chk_cnt++;
        if (d !== t + 2 * rows + 1)
            $display("FAIL %s_done_edge: got %0d want %0d", name, d, t + 2 * rows + 1);
        else pass_cnt++;
        chk_cnt++;
        if (d < 0) $display("FAIL %s_collision: got no done want %b", name, ec);
        else if (coll_q[d0] !== ec) $display("FAIL %s_collision: got %b want %b", name, coll_q[d0], ec);
        else pass_cnt++;
    endtask

    task automatic test_font();
        int t;
        mem[12'h050] = 8'hF0; mem[12'h051] = 8'h90; mem[12'h052] = 8'h90;
        mem[12'h053] = 8'h90; mem[12'h054] = 8'hF0;
        test_draw("font", 0, 0, 5, 12'h050, t);
        chk_cnt++;
        if (fb[0] !== 64'hF000_0000_0000_0000 || fb[1] !== 64'h9000_0000_0000_0000 ||
            fb[2] !== 64'h9000_0000_0000_0000 || fb[3] !== 64'h9000_0000_0000_0000 ||
            fb[4] !== 64'hF000_0000_0000_0000)
            $display("FAIL font_rows: got %h %h %h %h %h want F0.. 90.. 90.. 90.. F0..",
                     fb[0], fb[1], fb[2], fb[3], fb[4]);
        else pass_cnt++;
        chk_cnt++;
        if (done_q.size() == 0 || done_q[done_q.size() - 1] !== t + 11)
            $display("FAIL font_latency: got %0d want %0d",
                     (done_q.size() == 0) ? -1 : done_q[done_q.size() - 1], t + 11);
        else pass_cnt++;
    endtask

    task automatic test_redraw();
        int t;
        test_draw("redraw", 0, 0, 5, 12'h050, t);
        chk_cnt++;
        if ((fb[0] | fb[1] | fb[2] | fb[3] | fb[4]) !== 64'h0)
            $display("FAIL redraw_rows: got %h %h %h %h %h want all 0", fb[0], fb[1], fb[2], fb[3], fb[4]);
        else pass_cnt++;
        chk_cnt++;
        if (coll_q.size() == 0 || coll_q[coll_q.size() - 1] !== 1'b1)
            $display("FAIL redraw_vf: got %b want 1", (coll_q.size() == 0) ? 1'bx : coll_q[coll_q.size() - 1]);
        else pass_cnt++;
    endtask

    task automatic test_clip();
        int t;
        int w0;
        for (int k = 0; k < 4; k++) mem[12'h100 + k] = 8'hFF;
        w0 = obs_q.size();
        test_draw("clip", 60, 30, 4, 12'h100, t);
        chk_cnt++;
        if (fb[30] !== 64'h0000_0000_0000_000F || fb[31] !== 64'h0000_0000_0000_000F)
            $display("FAIL clip_rows: got %h %h want 000000000000000F x2", fb[30], fb[31]);
        else pass_cnt++;
        chk_cnt++;
        if (obs_q.size() - w0 !== 2 || fb[0] !== 64'h0)
            $display("FAIL clip_writes: got %0d writes row0 %h want 2 writes row0 0", obs_q.size() - w0, fb[0]);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        int t;
        int r0;
        mem[12'hFFF] = 8'h80;
        r0 = rd_q.size();
        test_draw("wrap", 70, 40, 1, 12'hFFF, t);
        chk_cnt++;
        if (rd_q.size() <= r0 || rd_q[r0] !== 12'hFFF)
            $display("FAIL wrap_mem_addr: got %h want fff", (rd_q.size() <= r0) ? -1 : rd_q[r0]);
        else pass_cnt++;
        chk_cnt++;
        if (fb[8] !== 64'h0200_0000_0000_0000)
            $display("FAIL wrap_row8: got %h want 0200000000000000", fb[8]);
        else pass_cnt++;
    endtask

    task automatic test_clear();
        int t;
        int w0;
        int d0;
        int d;
        int bad;
        logic [63:0] any_s;
        w0 = obs_q.size();
        d0 = done_q.size();
        issue(1'b1, 0, 0, 0, 0, t);
        wait_done(d0, d);
        bad = 0;
        for (int k = 0; k < 32; k++) begin
            if (w0 + k >= obs_q.size()) bad++;
            else if (obs_q[w0 + k].edge_n !== t + 1 + k || obs_q[w0 + k].addr !== k ||
                     obs_q[w0 + k].data !== 64'h0) bad++;
        end
        chk_cnt++;
        if (obs_q.size() - w0 !== 32 || bad != 0)
            $display("FAIL clear_writes: got %0d writes %0d bad want 32 writes 0 bad", obs_q.size() - w0, bad);
        else pass_cnt++;
        chk_cnt++;
        if (d !== t + 33) $display("FAIL clear_done_edge: got %0d want %0d", d, t + 33);
        else pass_cnt++;
        chk_cnt++;
        if (d < 0 || coll_q[d0] !== 1'b0) $display("FAIL clear_vf: got %0d want 0", (d < 0) ? -1 : int'(coll_q[d0]));
        else pass_cnt++;
        any_s = 64'h0;
        for (int k = 0; k < 32; k++) begin
            any_s = any_s | fb[k];
            ref_fb[k] = 64'h0;
        end
        chk_cnt++;
        if (any_s !== 64'h0) $display("FAIL clear_fb: got or-of-rows %h want 0", any_s);
        else pass_cnt++;
    endtask

    // n=0 commands with cmd_valid held: no bus activity, done every 2 cycles
    task automatic test_back_to_back();
        int d0;
        int r0;
        int f0;
        int w0;
        int t;
        d0 = done_q.size();
        r0 = rd_q.size();
        f0 = fbrd_q.size();
        w0 = obs_q.size();
        @(negedge clk);
        bus.cmd_clear = 1'b0;
        bus.cmd_x     = 8'd5;
        bus.cmd_y     = 8'd5;
        bus.cmd_n     = 4'd0;
        bus.cmd_i     = 12'h050;
        bus.cmd_valid = 1'b1;
        t = cyc + 1;
        chk_cnt++;
        if (bus.cmd_ready !== 1'b1) $display("FAIL b2b_ready: got %b want 1", bus.cmd_ready);
        else pass_cnt++;
        for (int k = 0; k < 50 && done_q.size() < d0 + 3; k++) begin
            @(negedge clk);
            #1;
        end
        bus.cmd_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk_cnt++;
            if (done_q.size() <= d0 + j) $display("FAIL b2b_done%0d: got none want edge %0d", j, t + 1 + 2 * j);
            else if (done_q[d0 + j] !== t + 1 + 2 * j || coll_q[d0 + j] !== 1'b0)
                $display("FAIL b2b_done%0d: got edge %0d vf %b want edge %0d vf 0",
                         j, done_q[d0 + j], coll_q[d0 + j], t + 1 + 2 * j);
            else pass_cnt++;
        end
        chk_cnt++;
        if (rd_q.size() != r0 || fbrd_q.size() != f0 || obs_q.size() != w0)
            $display("FAIL n0_no_access: got %0d mem rd %0d fb rd %0d fb wr want 0 0 0",
                     rd_q.size() - r0, fbrd_q.size() - f0, obs_q.size() - w0);
        else pass_cnt++;
    endtask

    // Reset during the WR cycle of row 2 of a 5-row draw
    task automatic test_reset_mid();
        int   t;
        int   w0;
        int   d0;
        int   rows;
        logic ec;
        wr_t  e;
        mem[12'h200] = 8'hAA; mem[12'h201] = 8'h55; mem[12'h202] = 8'hC3;
        mem[12'h203] = 8'h3C; mem[12'h204] = 8'h81;
        w0 = obs_q.size();
        d0 = done_q.size();
        issue(1'b0, 8, 10, 5, 12'h200, t);
        model_draw(8, 10, 5, 12'h200, t, 2, ec, rows);
        for (int k = 0; k < 20 && cyc < t + 4; k++) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_cnt++;
        if ({bus.mem_rd, bus.fb_rd, bus.fb_we, bus.done, bus.collision} !== 5'b0 ||
            bus.mem_addr !== 12'h0 || bus.fb_addr !== 5'h0 || bus.fb_wdata !== 64'h0)
            $display("FAIL midrst_outputs: got strobes %b addr %h/%h wdata %h want all 0",
                     {bus.mem_rd, bus.fb_rd, bus.fb_we, bus.done, bus.collision},
                     bus.mem_addr, bus.fb_addr, bus.fb_wdata);
        else pass_cnt++;
        chk_cnt++;
        if (bus.cmd_ready !== 1'b1) $display("FAIL midrst_ready: got %b want 1", bus.cmd_ready);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        for (int k = 0; k < rows; k++) begin
            e = exp_q.pop_front();
            chk_cnt++;
            if (w0 + k >= obs_q.size() || obs_q[w0 + k].addr !== e.addr || obs_q[w0 + k].data !== e.data)
                $display("FAIL midrst_row%0d: got %0d writes want row %0d data %h", k, obs_q.size() - w0, e.addr, e.data);
            else pass_cnt++;
        end
        chk_cnt++;
        if (obs_q.size() - w0 !== 2 || fb[12] !== 64'h0 || fb[10] !== ref_fb[10] || fb[11] !== ref_fb[11])
            $display("FAIL midrst_fb: got %0d writes rows %h %h %h want 2 writes rows %h %h 0",
                     obs_q.size() - w0, fb[10], fb[11], fb[12], ref_fb[10], ref_fb[11]);
        else pass_cnt++;
        chk_cnt++;
        if (done_q.size() != d0) $display("FAIL midrst_no_done: got %0d pulses want 0", done_q.size() - d0);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int t;
        test_reset();
        test_font();
        test_redraw();
        test_clip();
        test_wrap();
        test_clear();
        test_back_to_back();
        test_reset_mid();
        test_draw("post_reset", 3, 8, 5, 12'h050, t);
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
